// File: rtl/cvxif_issue_queue_pkg.sv
// Shared types and widths for the CV-X-IF issue queue: request/response structs,
// coprocessor instruction patterns and the decoded entry handed to the execute side.
package cvxif_issue_queue_pkg;

  localparam int unsigned MaxRgprPorts = 3;
  localparam int unsigned RdW          = 5;
  localparam int unsigned ImmW         = 7;
  localparam int unsigned F2W          = 2;

  typedef logic [3:0]                    copro_opcode_t;
  typedef logic [1:0]                    copro_hartid_t;
  typedef logic [3:0]                    copro_id_t;
  typedef logic [MaxRgprPorts-1:0][31:0] copro_registers_t;

  typedef struct packed {
    logic                    accept;
    logic                    writeback;
    logic [MaxRgprPorts-1:0] register_read;
  } copro_resp_t;

  typedef struct packed {
    logic [31:0]   instr;
    copro_hartid_t hartid;
    copro_id_t     id;
  } copro_issue_req_t;

  typedef struct packed {
    logic [MaxRgprPorts-1:0] rs_valid;
    copro_registers_t        rs;
  } copro_register_t;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   mask;
    copro_resp_t   resp;
    copro_opcode_t opcode;
  } copro_instr_t;

  typedef struct packed {
    copro_opcode_t    opcode;
    copro_hartid_t    hartid;
    copro_id_t        id;
    logic [RdW-1:0]   rd;
    logic [ImmW-1:0]  imm;
    logic [F2W-1:0]   f2;
    copro_registers_t registers;
  } dec_entry_t;

endpackage

// File: rtl/cvxif_dec_fifo.sv
// Circular buffer of decoded entries. Flush wins over push/pop; a full buffer
// refuses pushes even when a pop happens in the same cycle. Storage is not reset.
module cvxif_dec_fifo #(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   data_i,
  input  logic                     pop_i,
  output entry_t                   data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   usage_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t            mem [Depth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [PtrW:0]     cnt;
  logic              do_push, do_pop;

  assign full_o  = (cnt == (PtrW+1)'(Depth));
  assign empty_o = (cnt == '0);
  assign usage_o = cnt;
  assign data_o  = mem[rd_ptr];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/cvxif_issue_queue.sv
// CV-X-IF issue front end: matches offloaded instructions against fixed patterns and
// queues decoded entries. Define CVXIF_ISSUE_QUEUE_STATS_EN for accept/reject counters.
module cvxif_issue_queue
  import cvxif_issue_queue_pkg::*;
#(
  parameter int unsigned  NbInstr     = 1,
  parameter copro_instr_t CoproInstr [NbInstr] = '{default: '0},
  parameter int unsigned  NrRgprPorts = 2,
  parameter int unsigned  Depth       = 4,
  parameter type copro_issue_resp_t   = copro_resp_t,
  parameter type opcode_t             = copro_opcode_t,
  parameter type hartid_t             = copro_hartid_t,
  parameter type id_t                 = copro_id_t,
  parameter type x_issue_req_t        = copro_issue_req_t,
  parameter type x_issue_resp_t       = copro_resp_t,
  parameter type x_register_t         = copro_register_t,
  parameter type registers_t          = copro_registers_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  input  x_issue_req_t           issue_req_i,
  output logic                   issue_ready_o,
  output x_issue_resp_t          issue_resp_o,
  input  logic                   register_valid_i,
  input  x_register_t            register_i,
  output logic                   dec_valid_o,
  input  logic                   dec_ready_i,
  output dec_entry_t             dec_o,
`ifdef CVXIF_ISSUE_QUEUE_STATS_EN
  output logic [31:0]            accept_cnt_o,
  output logic [31:0]            reject_cnt_o,
`endif
  output logic [$clog2(Depth):0] count_o
);

  copro_instr_t            sel;
  copro_issue_resp_t       sel_resp;
  opcode_t                 sel_opcode;
  hartid_t                 hartid;
  id_t                     id;
  registers_t              regs;
  dec_entry_t              entry;
  logic                    match;
  logic [MaxRgprPorts-1:0] rr_eff;
  logic                    regs_ok, full, empty, push, pop;

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    match = 1'b0;
    sel   = '0;
    for (int i = NbInstr - 1; i >= 0; i--) begin
      if ((CoproInstr[i].mask & issue_req_i.instr) == CoproInstr[i].instr) begin
        match = 1'b1;
        sel   = CoproInstr[i];
      end
    end
  end

  assign sel_resp   = sel.resp;
  assign sel_opcode = sel.opcode;
  assign hartid     = issue_req_i.hartid;
  assign id         = issue_req_i.id;

  always_comb begin
    rr_eff = sel_resp.register_read;
    if (NrRgprPorts < MaxRgprPorts) rr_eff[MaxRgprPorts-1] = 1'b0;
  end

  assign regs_ok = (rr_eff == '0) ||
                   (register_valid_i && ((register_i.rs_valid & rr_eff) == rr_eff));

  // Unmatched or non-accepting instructions are always taken, queue state irrelevant.
  assign issue_ready_o = !match || !sel_resp.accept || (regs_ok && !full && !flush_i);
  assign push          = issue_valid_i && issue_ready_o && match && sel_resp.accept;

  always_comb begin
    issue_resp_o = '0;
    if (issue_valid_i && match) issue_resp_o = sel_resp;
  end

  always_comb begin
    regs = '0;
    for (int j = 0; j < MaxRgprPorts; j++) begin
      if (rr_eff[j]) regs[j] = register_i.rs[j];
    end
  end

  always_comb begin
    entry           = '0;
    entry.opcode    = sel_opcode;
    entry.hartid    = hartid;
    entry.id        = id;
    entry.rd        = issue_req_i.instr[11:7];
    entry.imm       = issue_req_i.instr[31:25];
    entry.f2        = issue_req_i.instr[26:25];
    entry.registers = regs;
  end

  assign dec_valid_o = !empty;
  assign pop         = dec_valid_o && dec_ready_i;

  cvxif_dec_fifo #(
    .Depth   (Depth),
    .entry_t (dec_entry_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .data_o  (dec_o),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (count_o)
  );

`ifdef CVXIF_ISSUE_QUEUE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accept_cnt_o <= '0;
      reject_cnt_o <= '0;
    end else begin
      if (push && (accept_cnt_o != '1)) accept_cnt_o <= accept_cnt_o + 32'd1;
      if (issue_valid_i && !match && (reject_cnt_o != '1)) reject_cnt_o <= reject_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cvxif_issue_queue.sv
// Scoreboard bench for cvxif_issue_queue (Depth 4, two register ports, four patterns).
// Build with CVXIF_ISSUE_QUEUE_STATS_EN to also cover the accept/reject counters.
module tb_cvxif_issue_queue;
  import cvxif_issue_queue_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned NbPat = 4;
  localparam copro_instr_t PATS [NbPat] = '{
    '{instr: 32'h0000_002B, mask: 32'h0000_007F,
      resp: '{accept: 1'b1, writeback: 1'b1, register_read: 3'b011}, opcode: 4'd1},
    '{instr: 32'h0000_002B, mask: 32'h0000_707F,
      resp: '{accept: 1'b1, writeback: 1'b0, register_read: 3'b001}, opcode: 4'd2},
    '{instr: 32'h0000_000B, mask: 32'h0000_007F,
      resp: '{accept: 1'b1, writeback: 1'b0, register_read: 3'b100}, opcode: 4'd3},
    '{instr: 32'h0000_005B, mask: 32'h0000_007F,
      resp: '{accept: 1'b0, writeback: 1'b0, register_read: 3'b000}, opcode: 4'd4}};

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             issue_valid_i;
  copro_issue_req_t issue_req_i;
  logic             issue_ready_o;
  copro_resp_t      issue_resp_o;
  logic             register_valid_i;
  copro_register_t  register_i;
  logic             dec_valid_o;
  logic             dec_ready_i;
  dec_entry_t       dec_o;
  logic [2:0]       count_o;
`ifdef CVXIF_ISSUE_QUEUE_STATS_EN
  logic [31:0]      accept_cnt_o, reject_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  dec_entry_t exp_q[$];
  int unsigned exp_acc = 0;
  int unsigned exp_rej = 0;
  logic [31:0] saved_rs1;

  always #5 clk_i = ~clk_i;

  cvxif_issue_queue #(
    .NbInstr     (NbPat),
    .CoproInstr  (PATS),
    .NrRgprPorts (2),
    .Depth       (Depth)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_req_i      (issue_req_i),
    .issue_ready_o    (issue_ready_o),
    .issue_resp_o     (issue_resp_o),
    .register_valid_i (register_valid_i),
    .register_i       (register_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .dec_o            (dec_o),
`ifdef CVXIF_ISSUE_QUEUE_STATS_EN
    .accept_cnt_o     (accept_cnt_o),
    .reject_cnt_o     (reject_cnt_o),
`endif
    .count_o          (count_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle at the negedge, checks against the model, then advances the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] rsv,
                      input logic drdy, input logic fl);
    copro_instr_t p;
    copro_resp_t  er;
    dec_entry_t   e;
    logic         m, rdy, psh, pp;
    logic [2:0]   rr;
    issue_valid_i          = v;
    issue_req_i.instr      = ins;
    issue_req_i.hartid     = 2'($urandom);
    issue_req_i.id         = 4'($urandom);
    register_valid_i       = 1'b1;
    register_i.rs_valid    = rsv;
    for (int j = 0; j < 3; j++) register_i.rs[j] = $urandom;
    dec_ready_i            = drdy;
    flush_i                = fl;
    #1;
    m = 1'b0;
    p = '0;
    for (int i = 0; i < NbPat; i++) begin
      if (!m && ((PATS[i].mask & ins) == PATS[i].instr)) begin
        m = 1'b1;
        p = PATS[i];
      end
    end
    rr    = p.resp.register_read;
    rr[2] = 1'b0;
    rdy   = !m || !p.resp.accept || (((rsv & rr) == rr) && (exp_q.size() < Depth) && !fl);
    er    = '0;
    if (v && m) er = p.resp;
    chk("issue_ready", issue_ready_o, rdy);
    chk("issue_resp", issue_resp_o, er);
    chk("count", count_o, exp_q.size());
    chk("dec_valid", dec_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("dec_data", dec_o, exp_q[0]);
`ifdef CVXIF_ISSUE_QUEUE_STATS_EN
    chk("accept_cnt", accept_cnt_o, exp_acc);
    chk("reject_cnt", reject_cnt_o, exp_rej);
`endif
    psh = v && rdy && m && p.resp.accept;
    pp  = (exp_q.size() > 0) && drdy && !fl;
    e           = '0;
    e.opcode    = p.opcode;
    e.hartid    = issue_req_i.hartid;
    e.id        = issue_req_i.id;
    e.rd        = ins[11:7];
    e.imm       = ins[31:25];
    e.f2        = ins[26:25];
    for (int j = 0; j < 3; j++) e.registers[j] = rr[j] ? register_i.rs[j] : 32'h0;
    if (psh) exp_acc++;
    if (v && !m) exp_rej++;
    if (fl) exp_q.delete();
    else begin
      if (pp)  void'(exp_q.pop_front());
      if (psh) exp_q.push_back(e);
    end
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  lows [5];
    lows = '{7'h2B, 7'h2B, 7'h0B, 7'h33, 7'h5B};
    rst_ni = 1'b0;
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    issue_req_i = '0;
    register_valid_i = 1'b0;
    register_i = '0;
    dec_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_count", count_o, 0);
    chk("rst_dec_valid", dec_valid_o, 1'b0);
    chk("rst_ready", issue_ready_o, 1'b1);
    rst_ni = 1'b1;

    // Fill to full, lowest matching pattern wins, fifth blocked, unmatched still taken.
    for (int k = 0; k < 4; k++) step(1'b1, 32'hA5A0_002B + (k << 7), 3'b011, 1'b0, 1'b0);
    chk("full_count", count_o, 4);
    chk("prio_opcode", dec_o.opcode, 4'd1);
    step(1'b1, 32'h0000_002B, 3'b011, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 3'b000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_005B, 3'b000, 1'b0, 1'b0);
    // Full with pop and push attempt together: pop only.
    step(1'b1, 32'h0000_002B, 3'b011, 1'b1, 1'b0);
    chk("full_pop_count", count_o, 3);
    // Flush against a valid issue.
    step(1'b1, 32'h0000_002B, 3'b011, 1'b0, 1'b1);
    chk("flush_count", count_o, 0);
    chk("flush_dec_valid", dec_valid_o, 1'b0);
    // Missing rs[1] stalls; with both valid it pushes and captures rs[1].
    step(1'b1, 32'h1234_572B, 3'b001, 1'b0, 1'b0);
    step(1'b1, 32'h1234_572B, 3'b011, 1'b0, 1'b0);
    saved_rs1 = register_i.rs[1];
    #1 chk("rs1_capture", dec_o.registers[1], saved_rs1);
    // register_read[2] ignored with two ports; push+pop keeps count.
    step(1'b1, 32'hFE00_0F8B, 3'b000, 1'b1, 1'b0);
    chk("pushpop_count", count_o, 1);
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    for (int k = 0; k < 80; k++) begin
      r = $urandom;
      step(($urandom_range(0, 3) != 0), {r[31:7], lows[$urandom_range(0, 4)]},
           ($urandom_range(0, 3) != 0) ? 3'b011 : 3'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a cycle with two entries queued.
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
    step(1'b1, 32'h0000_002B, 3'b011, 1'b0, 1'b0);
    step(1'b1, 32'h0000_000B, 3'b000, 1'b0, 1'b0);
    chk("pre_rst_count", count_o, 2);
    issue_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_dec_valid", dec_valid_o, 1'b0);
    chk("async_rst_count", count_o, 0);
    exp_q.delete();
    exp_acc = 0;
    exp_rej = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 32'h0000_002B, 3'b011, 1'b0, 1'b0);
`ifdef CVXIF_ISSUE_QUEUE_STATS_EN
    chk("post_rst_accept_cnt", accept_cnt_o, 1);
`endif
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
